// File: rtl/down_counter_pkg.sv
// Shared definitions for the loadable down-counting timer: state encoding and default width.
package down_counter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counting timer with valid/ready load, one-cycle terminal-count pulse
// and optional auto-reload of the last loaded value.
module down_counter_timer
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             abort,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_value,
  output logic             load_ready,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             load_fire;

  assign load_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy       = (state_q == ST_RUN);
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (load_fire) begin
      if (load_value != '0) begin
        cnt_d    = load_value;
        reload_d = load_value;
        state_d  = ST_RUN;
      end else begin
        // A zero load expires immediately: pulse tc and park in DONE.
        cnt_d   = '0;
        tc_d    = 1'b1;
        state_d = ST_DONE;
      end
    end else if (busy && enable) begin
      if (cnt_q == ONE) begin
        tc_d = 1'b1;
        if (AUTO_RELOAD) begin
          cnt_d = reload_q;
        end else begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end else begin
        cnt_d = cnt_q - ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign out = cnt_q;
  assign tc  = tc_q;

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench: one-shot and auto-reload timers driven in parallel, compared every
// cycle against a two-mode (running / not running) behavioural model plus literal checks.
module tb_down_counter_timer;

  logic       clock = 1'b0;
  logic       reset, enable, abort, load_valid;
  logic [7:0] load_value;
  logic       ready0, tc0, busy0, ready1, tc1, busy1;
  logic [7:0] out0, out1;

  int checks = 0;
  int errors = 0;
  bit mdl_on = 1'b0;

  // Model: per instance (0 = one-shot, 1 = auto-reload).
  logic [7:0] m_cnt[2];
  logic [7:0] m_rel[2];
  bit         m_run[2];
  bit         m_tc[2];

  always #5 clock = ~clock;

  down_counter_timer #(.WIDTH(8), .AUTO_RELOAD(1'b0)) u_one (
    .clock(clock), .reset(reset), .enable(enable), .abort(abort),
    .load_valid(load_valid), .load_value(load_value), .load_ready(ready0),
    .out(out0), .tc(tc0), .busy(busy0)
  );

  down_counter_timer #(.WIDTH(8), .AUTO_RELOAD(1'b1)) u_ar (
    .clock(clock), .reset(reset), .enable(enable), .abort(abort),
    .load_valid(load_valid), .load_value(load_value), .load_ready(ready1),
    .out(out1), .tc(tc1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (reset || abort) begin
        m_cnt[i] = 8'd0;
        m_run[i] = 1'b0;
        m_tc[i]  = 1'b0;
        if (reset) m_rel[i] = 8'd0;
      end else if (!m_run[i] && load_valid) begin
        if (load_value != 8'd0) begin
          m_cnt[i] = load_value;
          m_rel[i] = load_value;
          m_run[i] = 1'b1;
          m_tc[i]  = 1'b0;
        end else begin
          m_cnt[i] = 8'd0;
          m_tc[i]  = 1'b1;
        end
      end else if (m_run[i] && enable) begin
        if (m_cnt[i] == 8'd1) begin
          m_tc[i] = 1'b1;
          if (i == 1) m_cnt[i] = m_rel[i];
          else begin
            m_cnt[i] = 8'd0;
            m_run[i] = 1'b0;
          end
        end else begin
          m_cnt[i] = m_cnt[i] - 8'd1;
          m_tc[i]  = 1'b0;
        end
      end else begin
        m_tc[i] = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (mdl_on) begin
      check("mdl_out0", out0, m_cnt[0]);
      check("mdl_tc0", tc0, m_tc[0]);
      check("mdl_busy0", busy0, m_run[0]);
      check("mdl_ready0", ready0, !m_run[0]);
      check("mdl_out1", out1, m_cnt[1]);
      check("mdl_tc1", tc1, m_tc[1]);
      check("mdl_busy1", busy1, m_run[1]);
      check("mdl_ready1", ready1, !m_run[1]);
    end
  end

  task automatic step(input bit en, input bit lv, input logic [7:0] val, input bit ab,
                      input bit rst);
    enable     = en;
    load_valid = lv;
    load_value = val;
    abort      = ab;
    reset      = rst;
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_o[10] = '{2, 1, 3, 2, 1, 3, 2, 1, 3, 2};
    int n_en, n_clk;
    bit seen;

    enable = 0; load_valid = 0; load_value = 0; abort = 0; reset = 1;
    @(negedge clock);

    // 1: reset
    step(0, 0, 0, 0, 1);
    mdl_on = 1'b1;
    step(0, 0, 0, 0, 1);
    check("rst_out", out0, 0);
    check("rst_tc", tc0, 0);
    check("rst_busy", busy0, 0);
    check("rst_ready", ready0, 1);
    step(0, 0, 0, 0, 0);

    // 2: load 5, count to zero
    step(1, 1, 8'd5, 0, 0);
    check("t2_load_out", out0, 5);
    check("t2_busy", busy0, 1);
    check("t2_ready", ready0, 0);
    for (int k = 4; k >= 0; k--) begin
      step(1, 0, 0, 0, 0);
      check("t2_out", out0, k);
      check("t2_tc", tc0, (k == 0));
    end
    check("t2_done_ready", ready0, 1);
    check("t2_done_busy", busy0, 0);
    step(1, 0, 0, 0, 0);
    check("t2_tc_once", tc0, 0);
    check("t2_hold0", out0, 0);

    // 3: load 4, enable alternating
    step(0, 0, 0, 1, 0);
    step(0, 1, 8'd4, 0, 0);
    n_en = 0; n_clk = 0; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step((i % 2) == 0, 0, 0, 0, 0);
      n_clk++;
      if ((i % 2) == 0) n_en++;
      if (tc0) seen = 1;
    end
    check("t3_tc_seen", seen, 1);
    check("t3_en_cycles", n_en, 4);
    check("t3_clocks", n_clk, 7);

    // 4: auto-reload, load 3, 10 enabled cycles
    step(0, 0, 0, 1, 0);
    step(0, 1, 8'd3, 0, 0);
    check("t4_load_out", out1, 3);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0);
      check("t4_out", out1, exp_o[i]);
      check("t4_tc", tc1, (exp_o[i] == 3));
      check("t4_busy", busy1, 1);
    end

    // 5: abort with same-cycle load
    step(0, 0, 0, 1, 0);
    step(0, 1, 8'd8, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    check("t5_pre_out", out0, 5);
    step(1, 1, 8'd9, 1, 0);
    check("t5_out", out0, 0);
    check("t5_tc", tc0, 0);
    check("t5_busy", busy0, 0);
    check("t5_ready", ready0, 1);
    check("t5_out_ar", out1, 0);
    step(1, 0, 0, 0, 0);
    check("t5_load_ignored", out0, 0);
    check("t5_idle_busy", busy0, 0);

    // 6: zero load, full-range load, reset mid-count
    step(0, 1, 8'd0, 0, 0);
    check("t6_z_tc", tc0, 1);
    check("t6_z_out", out0, 0);
    check("t6_z_busy", busy0, 0);
    check("t6_z_tc_ar", tc1, 1);
    step(0, 0, 0, 0, 0);
    check("t6_z_tc_drop", tc0, 0);
    step(0, 1, 8'd255, 0, 0);
    check("t6_255_out", out0, 255);
    n_en = 0; seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      step(1, 0, 0, 0, 0);
      n_en++;
      if (tc0) seen = 1;
    end
    check("t6_255_cycles", n_en, 255);
    check("t6_255_out0", out0, 0);
    check("t6_255_reload", out1, 255);
    check("t6_255_tc_ar", tc1, 1);
    step(0, 0, 0, 1, 0);
    step(0, 1, 8'd200, 0, 0);
    for (int i = 0; i < 100; i++) step(1, 0, 0, 0, 0);
    check("t6_mid_out", out0, 100);
    step(1, 1, 8'd7, 0, 1);
    check("t6_rst_out", out0, 0);
    check("t6_rst_tc", tc0, 0);
    check("t6_rst_busy", busy0, 0);
    check("t6_rst_ready", ready0, 1);
    check("t6_rst_out_ar", out1, 0);
    step(0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
